addr_bridge_n: RTL

ADDR_BRIDGE_N -- requirements
Module: addr_bridge_n

---
 rtl/addr_bridge_n_pkg.sv | 15 +
 rtl/addr_bridge_n_if.sv | 26 ++
 rtl/addr_bridge_n_rd_track_pipe.sv | 41 ++++
 rtl/addr_bridge_n.sv | 116 +++++++++++
 4 files changed

// File: rtl/addr_bridge_n_pkg.sv
// Shared types and constants for the address-decode bridge.
package bridge_pkg;

    localparam int MAX_SLV = 8;
    localparam int SEL_W   = $clog2(MAX_SLV);

    // One read-tracking slot: whether a read was issued, where it went,
    // and whether it decoded to nothing.
    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] sel;
        logic             miss;
    } trk_entry_t;

endpackage

// File: rtl/addr_bridge_n_if.sv
// Upstream request/response bus of the bridge.
//
// Handshake: bridge_en qualifies a request in the cycle it is high; there is
// no backpressure, so every qualified request is accepted that cycle. A read
// (bridge_wen == 0) is answered by a single-cycle bridge_rvalid pulse exactly
// RD_LAT cycles later, with bridge_rdata/bridge_rerr meaningful only while
// bridge_rvalid is high. Writes are never answered.
interface addr_bridge_n_if;
    logic        bridge_en;
    logic [3:0]  bridge_wen;
    logic [31:0] bridge_addr;
    logic [31:0] bridge_wdata;
    logic [31:0] bridge_rdata;
    logic        bridge_rvalid;
    logic        bridge_rerr;

    modport master (
        output bridge_en, bridge_wen, bridge_addr, bridge_wdata,
        input  bridge_rdata, bridge_rvalid, bridge_rerr
    );

    modport slave (
        input  bridge_en, bridge_wen, bridge_addr, bridge_wdata,
        output bridge_rdata, bridge_rvalid, bridge_rerr
    );
endinterface

// File: rtl/addr_bridge_n_rd_track_pipe.sv
// Fixed-depth shift pipeline that remembers where each read went so the
// returning data can be steered and flagged RD_LAT cycles later.
module rd_track_pipe
    import bridge_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  trk_entry_t push,
    output trk_entry_t head
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $fatal(1, "rd_track_pipe: RD_LAT must be in 1..4");
    end

    trk_entry_t [RD_LAT-1:0] stage_q;
    trk_entry_t [RD_LAT-1:0] stage_d;

    // Shift every cycle; stage 0 takes the new entry.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = push;
        for (int i = 1; i < RD_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Reset wipes in-flight reads so nothing is returned after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign head = stage_q[RD_LAT-1];

endmodule

// File: rtl/addr_bridge_n.sv
// Address-decoding bridge: one upstream port fanned out to NUM_SLV slaves
// by base/mask match, lowest index winning, with read-return steering and a
// saturating decode-miss counter.
module addr_bridge_n
    import bridge_pkg::*;
#(
    parameter int                      NUM_SLV  = 4,
    parameter logic [32*NUM_SLV-1:0]   SLV_BASE = {32'h0000_0000, 32'h0000_0000,
                                                   32'h1fc0_0000, 32'h1ffa_0000},
    parameter logic [32*NUM_SLV-1:0]   SLV_MASK = {32'h0000_0000, 32'he000_0000,
                                                   32'hfff0_0000, 32'hffff_0000},
    parameter int                      RD_LAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    addr_bridge_n_if.slave         bus,
    output logic [NUM_SLV-1:0]     slv_en,
    output logic [4*NUM_SLV-1:0]   slv_wen,
    output logic [31:0]            slv_addr,
    output logic [31:0]            slv_wdata,
    input  logic [32*NUM_SLV-1:0]  slv_rdata,
    input  logic                   miss_clr,
    output logic [15:0]            miss_cnt
);

    if (NUM_SLV < 2 || NUM_SLV > MAX_SLV) begin : g_bad_num
        $fatal(1, "addr_bridge_n: NUM_SLV must be in 2..8");
    end

    logic             hit;
    logic [SEL_W-1:0] sel;
    trk_entry_t       push;
    trk_entry_t       head;
    logic [15:0]      miss_cnt_q;
    logic [15:0]      miss_cnt_d;

    // Address decode; scanning downward leaves the lowest matching index.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((bus.bridge_addr & SLV_MASK[i*32 +: 32]) ==
                (SLV_BASE[i*32 +: 32] & SLV_MASK[i*32 +: 32])) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

    // Route enables to the selected slave only; a miss drives nothing.
    always_comb begin
        slv_en  = '0;
        slv_wen = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (hit && sel == SEL_W'(i)) begin
                slv_en[i]          = bus.bridge_en;
                slv_wen[i*4 +: 4]  = bus.bridge_wen;
            end
        end
    end

    assign slv_addr  = bus.bridge_addr;
    assign slv_wdata = bus.bridge_wdata;

    // Record every read, including misses, so each one gets an answer.
    always_comb begin
        push       = '0;
        push.valid = bus.bridge_en && (bus.bridge_wen == 4'h0);
        push.sel   = sel;
        push.miss  = !hit;
    end

    rd_track_pipe #(.RD_LAT(RD_LAT)) u_track (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .head (head)
    );

    // Steer the returning slave data; misses and idle cycles read as zero.
    always_comb begin
        bus.bridge_rdata = 32'h0;
        if (head.valid && !head.miss) begin
            for (int i = 0; i < NUM_SLV; i++) begin
                if (head.sel == SEL_W'(i)) begin
                    bus.bridge_rdata = slv_rdata[i*32 +: 32];
                end
            end
        end
    end

    assign bus.bridge_rvalid = head.valid;
    assign bus.bridge_rerr   = head.valid && head.miss;

    // Next miss count: clear wins, otherwise count misses up to all-ones.
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (miss_clr) begin
            miss_cnt_d = 16'h0;
        end else if (bus.bridge_en && !hit && miss_cnt_q != 16'hffff) begin
            miss_cnt_d = miss_cnt_q + 16'h1;
        end
    end

    // Miss counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt_q <= 16'h0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign miss_cnt = miss_cnt_q;

endmodule
